// File: rtl/alu_seq.sv
// Multi-cycle 8-bit ALU behind the control unit's ALU states: single-cycle ops,
// shift-add multiply, restoring divide. Divider present only with `ALU_DIV_EN.
module alu_seq #(
  parameter int MUL_ITER = 8,
  parameter int DIV_ITER = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_executing,
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_s,
  output logic       flag_v,
  output logic       alu_done,
  output logic       busy
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
  localparam logic [3:0] OP_MLO = 4'd12, OP_DIV = 4'd14;

  typedef enum logic [1:0] {IDLE, SIMPLE, MUL, DIV} state_t;

  state_t     state, state_nx;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic       cin_q;
  logic [7:0] cnt;
  // p_hi/p_lo: product {hi,lo} while multiplying, {remainder,quotient} while dividing
  logic [7:0] p_hi, p_lo;
  logic       finish;

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (alu_executing) begin
          if (op < OP_MLO)      state_nx = SIMPLE;
          else if (op < OP_DIV) state_nx = MUL;
`ifdef ALU_DIV_EN
          else                  state_nx = DIV;
`else
          else                  state_nx = SIMPLE;
`endif
        end
      end
      SIMPLE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      MUL: begin
        if (cnt == 8'(MUL_ITER - 1)) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        if (b_q == 8'd0 || cnt == 8'(DIV_ITER - 1)) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign alu_done = (state == IDLE);

  // ---------------- single-cycle datapath ----------------
  logic [7:0] add_b, sub_b, s_res;
  logic       add_c, sub_c, s_c, s_v;
  logic [8:0] sum9, dif9;

  always_comb begin
    add_b = (op_q == OP_INC) ? 8'd1 : b_q;
    sub_b = (op_q == OP_DEC) ? 8'd1 : b_q;
    add_c = (op_q == OP_ADC) & cin_q;
    sub_c = (op_q == OP_SBC) & cin_q;
    sum9  = {1'b0, a_q} + {1'b0, add_b} + {8'd0, add_c};
    // bit 8 of the 9-bit difference is the borrow out
    dif9  = {1'b0, a_q} - {1'b0, sub_b} - {8'd0, sub_c};
    s_res = 8'd0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        s_res = sum9[7:0];
        s_c   = sum9[8];
        s_v   = (a_q[7] == add_b[7]) && (sum9[7] != a_q[7]);
      end
      OP_SUB, OP_SBC: begin
        s_res = dif9[7:0];
        s_c   = dif9[8];
        s_v   = (a_q[7] != sub_b[7]) && (dif9[7] != a_q[7]);
      end
      OP_AND: s_res = a_q & b_q;
      OP_OR:  s_res = a_q | b_q;
      OP_XOR: s_res = a_q ^ b_q;
      OP_NOT: s_res = ~a_q;
      OP_SHL: begin s_res = {a_q[6:0], 1'b0}; s_c = a_q[7]; end
      OP_SHR: begin s_res = {1'b0, a_q[7:1]}; s_c = a_q[0]; end
      OP_INC: begin s_res = sum9[7:0]; s_c = sum9[8]; end
      OP_DEC: begin s_res = dif9[7:0]; s_c = dif9[8]; end
      // only divide ops reach here, and only when the divider is absent
      default: begin s_res = 8'd0; s_c = 1'b1; end
    endcase
  end

  // ---------------- multiplier step ----------------
  logic [8:0] mul_sum9;
  logic [7:0] mul_hi_nx, mul_lo_nx;

  always_comb begin
    mul_sum9  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : 9'd0);
    mul_hi_nx = mul_sum9[8:1];
    mul_lo_nx = {mul_sum9[0], p_lo[7:1]};
  end

`ifdef ALU_DIV_EN
  // ---------------- divider step ----------------
  logic [8:0] r_sh, r_try;
  logic       q_bit;
  logic [7:0] div_hi_nx, div_lo_nx;

  always_comb begin
    r_sh      = {p_hi, p_lo[7]};
    r_try     = r_sh - {1'b0, b_q};
    q_bit     = ~r_try[8];
    div_hi_nx = q_bit ? r_try[7:0] : r_sh[7:0];
    div_lo_nx = {p_lo[6:0], q_bit};
  end
`endif

  // ---------------- completion value ----------------
  logic [7:0] f_res;
  logic       f_c, f_v;

  always_comb begin
    f_res = s_res;
    f_c   = s_c;
    f_v   = s_v;
    case (state)
      MUL: begin
        f_v = 1'b0;
        if (op_q == OP_MLO) begin
          f_res = mul_lo_nx;
          f_c   = |mul_hi_nx;
        end else begin
          f_res = mul_hi_nx;
          f_c   = 1'b0;
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        f_v = 1'b0;
        if (b_q == 8'd0) begin
          f_res = (op_q == OP_DIV) ? 8'hFF : a_q;
          f_c   = 1'b1;
        end else begin
          f_res = (op_q == OP_DIV) ? div_lo_nx : div_hi_nx;
          f_c   = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 4'd0;
      a_q    <= 8'd0;
      b_q    <= 8'd0;
      cin_q  <= 1'b0;
      cnt    <= 8'd0;
      p_hi   <= 8'd0;
      p_lo   <= 8'd0;
      result <= 8'd0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_s <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (alu_executing) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
            cnt   <= 8'd0;
            p_hi  <= 8'd0;
            // divider shifts the dividend out of p_lo; multiplier shifts the multiplier
            p_lo  <= (op[3:1] == 3'b111) ? a : b;
          end
        end
        MUL: begin
          p_hi <= mul_hi_nx;
          p_lo <= mul_lo_nx;
          cnt  <= cnt + 8'd1;
        end
`ifdef ALU_DIV_EN
        DIV: begin
          p_hi <= div_hi_nx;
          p_lo <= div_lo_nx;
          cnt  <= cnt + 8'd1;
        end
`endif
        default: ;
      endcase
      if (finish) begin
        result <= f_res;
        flag_z <= (f_res == 8'd0);
        flag_c <= f_c;
        flag_s <= f_res[7];
        flag_v <= f_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: latency, results and flags for every op,
// held start, operand changes after start and reset in mid-multiply.
module tb_alu_seq;

  logic       clk, rst, alu_executing, cin;
  logic [3:0] op;
  logic [7:0] a, b, result;
  logic       flag_z, flag_c, flag_s, flag_v, alu_done, busy;
  int         vectors = 0;
  int         miscompares = 0;
  int         n;

  alu_seq dut (
    .clk(clk), .rst(rst), .alu_executing(alu_executing), .op(op), .a(a), .b(b),
    .cin(cin), .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
    .flag_v(flag_v), .alu_done(alu_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // counts cycles with alu_done low, bounded so a stuck DUT still finishes
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (alu_done !== 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  // flags packed as {z, c, s, v}; lat is the number of cycles alu_done stays low
  task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic ci, input logic [7:0] er,
                       input logic [3:0] ef, input int lat);
    int k;
    op = o; a = x; b = y; cin = ci; alu_executing = 1'b1;
    tick();
    alu_executing = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    wait_done(k);
    chk({tag, "/lat"},   16'(k), 16'(lat));
    chk({tag, "/res"},   16'(result), 16'(er));
    chk({tag, "/flags"}, 16'({flag_z, flag_c, flag_s, flag_v}), 16'(ef));
  endtask

  initial begin
    rst = 1'b1; alu_executing = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/done", 16'(alu_done), 16'd1);
    chk("rst/busy", 16'(busy), 16'd0);
    @(negedge clk);
    alu_executing = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk("idle/done",  16'(alu_done), 16'd1);
    chk("idle/busy",  16'(busy), 16'd0);
    chk("idle/res",   16'(result), 16'h00);
    chk("idle/flags", 16'({flag_z, flag_c, flag_s, flag_v}), 16'h0);

    do_op("add_ovf", 4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 1);
    do_op("sub_brw", 4'd2,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b0110, 1);
    do_op("add_cin", 4'd0,  8'h10, 8'h20, 1'b1, 8'h30, 4'b0000, 1);
    do_op("adc",     4'd1,  8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100, 1);
    do_op("sbc",     4'd3,  8'h80, 8'h00, 1'b1, 8'h7F, 4'b0001, 1);
    do_op("sub_v",   4'd2,  8'h50, 8'hB0, 1'b0, 8'hA0, 4'b0111, 1);
    do_op("and",     4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 1);
    do_op("or",      4'd5,  8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b0010, 1);
    do_op("xor",     4'd6,  8'hAA, 8'hAA, 1'b0, 8'h00, 4'b1000, 1);
    do_op("not",     4'd7,  8'h55, 8'h00, 1'b0, 8'hAA, 4'b0010, 1);
    do_op("shl",     4'd8,  8'h81, 8'h00, 1'b0, 8'h02, 4'b0100, 1);
    do_op("shr",     4'd9,  8'h01, 8'h00, 1'b0, 8'h00, 4'b1100, 1);
    do_op("inc",     4'd10, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b1100, 1);
    do_op("dec",     4'd11, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0110, 1);

    do_op("mullo",    4'd12, 8'h10, 8'h20, 1'b0, 8'h00, 4'b1100, 8);
    do_op("mulhi",    4'd13, 8'h10, 8'h20, 1'b0, 8'h02, 4'b0000, 8);
    do_op("mullo_ff", 4'd12, 8'hFF, 8'hFF, 1'b0, 8'h01, 4'b0100, 8);
    do_op("mulhi_ff", 4'd13, 8'hFF, 8'hFF, 1'b0, 8'hFE, 4'b0010, 8);

`ifdef ALU_DIV_EN
    do_op("div",   4'd14, 8'd200, 8'd7, 1'b0, 8'd28,  4'b0000, 8);
    do_op("mod",   4'd15, 8'd200, 8'd7, 1'b0, 8'd4,   4'b0000, 8);
    do_op("div_0", 4'd14, 8'd5,   8'd0, 1'b0, 8'hFF,  4'b0110, 1);
    do_op("mod_0", 4'd15, 8'd5,   8'd0, 1'b0, 8'd5,   4'b0100, 1);
`else
    do_op("div_off", 4'd14, 8'd200, 8'd7, 1'b0, 8'h00, 4'b1100, 1);
    do_op("mod_off", 4'd15, 8'd5,   8'd0, 1'b0, 8'h00, 4'b1100, 1);
`endif

    // start held high across a whole multiply; operands change right after the start edge
    op = 4'd12; a = 8'd3; b = 8'd5; alu_executing = 1'b1;
    tick();
    a = 8'd7; b = 8'd9;
    wait_done(n);
    chk("hold1/lat", 16'(n), 16'd8);
    chk("hold1/res", 16'(result), 16'h0F);
    tick();
    alu_executing = 1'b0;
    chk("hold2/start", 16'(alu_done), 16'd0);
    wait_done(n);
    chk("hold2/lat", 16'(n), 16'd8);
    chk("hold2/res", 16'(result), 16'h3F);
    tick(); tick();
    chk("hold/idle", 16'(alu_done), 16'd1);
    chk("hold/keep", 16'(result), 16'h3F);

    // reset during cycle 4 of a multiply
    op = 4'd12; a = 8'd3; b = 8'd3; alu_executing = 1'b1;
    tick();
    alu_executing = 1'b0;
    tick(); tick(); tick();
    chk("midmul/busy", 16'(busy), 16'd1);
    chk("midmul/res",  16'(result), 16'h3F);
    #2 rst = 1'b1;
    #1;
    chk("arst/done",  16'(alu_done), 16'd1);
    chk("arst/busy",  16'(busy), 16'd0);
    chk("arst/res",   16'(result), 16'h00);
    chk("arst/flags", 16'({flag_z, flag_c, flag_s, flag_v}), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_op("post_rst", 4'd0, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle 8-bit ALU that sits directly downstream of the control unit's ALU states.
- Consumes the control unit's `alu_executing` strobe, latches operands and opcode, and computes the result.
- Returns `alu_done` using the control unit's handshake: `done` high while idle, low for at least one cycle while busy, then a rising edge when the result is valid.
- Single-cycle logic ops plus iterative shift-add multiply and restoring divide.

Parameters:
- MUL_ITER, 8, iterations of the shift-add multiplier (one bit per cycle).
- DIV_ITER, 8, iterations of the restoring divider (one quotient bit per cycle).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- alu_executing  input  1  start strobe from the control unit; sampled only in IDLE
- op  input  4  opcode, latched on start
- a  input  8  operand A, latched on start
- b  input  8  operand B, latched on start
- cin  input  1  carry/borrow in, latched on start
- result  output  8  registered result; held until the next completion
- flag_z  output  1  zero: result==0
- flag_c  output  1  carry/borrow/shift-out (per-op rules below)
- flag_s  output  1  sign: result[7]
- flag_v  output  1  signed overflow (ADD/ADC/SUB/SBC only, else 0)
- alu_done  output  1  high when idle/complete, low while busy
- busy  output  1  high when state != IDLE

Behaviour:
- Reset (async): state=IDLE, alu_done=1, busy=0, result=0, all flags=0, internal accumulators=0. Reset mid-operation aborts the operation with no completion edge.
- States: IDLE, SIMPLE, MUL, DIV.
- IDLE: on alu_executing=1, latch op/a/b/cin; next state is SIMPLE for ops 0-11, MUL for 12-13, DIV for 14-15; alu_done goes 0 on that edge. Otherwise stay in IDLE.
- SIMPLE: one cycle. Register result and flags, return to IDLE, alu_done=1. The done pulse is low for exactly 1 cycle; total latency is 2 clocks from the start edge to done high.
- MUL: MUL_ITER cycles of shift-add into a 16-bit product, then register the result, return to IDLE, alu_done=1. Latency is MUL_ITER+1 clocks.
- DIV: MUL_ITER-independent. DIV_ITER cycles of restoring division, then IDLE. Latency is DIV_ITER+1 clocks.
  - b==0: skip iterations. DIV result=0xFF, MOD result=a, flag_c=1. Latency 2 clocks.
- alu_executing is ignored while busy; no queuing. Operand inputs may change after the start edge without effect.
- result and flags are updated only on completion; intermediate values are never visible.
- Opcodes:
  - 0 ADD
  - 1 ADC (+cin)
  - 2 SUB
  - 3 SBC (-cin)
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT A
  - 8 SHL (C=a[7])
  - 9 SHR logical (C=a[0])
  - 10 INC
  - 11 DEC
  - 12 MULLO (C=1 if high byte !=0)
  - 13 MULHI
  - 14 DIV (unsigned quotient)
  - 15 MOD (unsigned remainder)
- Arithmetic:
  - ADD/ADC/INC: 9-bit sum; C=bit 8.
  - SUB/SBC/DEC: C=1 on borrow (unsigned a < b+cin). INC/DEC update C, V=0.
  - V = signed overflow of the 8-bit add/sub.
  - Logic ops: C=0, V=0.
  - MUL/DIV: V=0; C=0 unless stated above.
- Z and S are always derived from the final 8-bit result.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: DIV state and divider datapath are present; ops 14/15 behave as above.
- Undefined: no divider logic. Ops 14/15 take the SIMPLE path (2-clock latency), result=0, flag_c=1, flag_z=1, flag_s=0, flag_v=0.

Test Plan:
- Reset held, then released with no start → alu_done=1, busy=0, result=0x00, all flags 0; start pulse asserted during reset is ignored.
- ADD a=0x7F b=0x01 → alu_done low exactly 1 cycle, high at start+2; result=0x80, S=1, V=1, C=0, Z=0. Then SUB a=0x00 b=0x01 → result=0xFF, C=1.
- MULLO a=0x10 b=0x20 → done low 8 cycles, rises at start+9; result=0x00, Z=1, C=1. MULHI with the same operands → result=0x02.
- DIV a=200 b=7 → result=28 at start+9; MOD → result=4. DIV a=5 b=0 → result=0xFF, C=1, done at start+2 (ALU_DIV_EN defined). With ALU_DIV_EN undefined → result=0, C=1.
- Start held high continuously during a MUL → second start accepted only in IDLE; exactly one result per accepted start; operand changes mid-operation have no effect.
- Assert rst at cycle 4 of a MUL → immediate IDLE, alu_done=1, result=0; a subsequent ADD 0x01+0x01 completes with result=0x02.
